// File: rtl/lc_ctrl_otp_prog_pkg.sv
// Shared types and constants for the LC partition programming requester.
// The LC image is the concatenated life cycle state and transition count fields.
package lc_ctrl_otp_prog_pkg;

   typedef enum logic [3:0] {
      On  = 4'b0101,
      Off = 4'b1010
   } lc_tx_t;

   localparam int LcStateWidth = 320;
   localparam int LcCountWidth = 384;
   localparam int LcDataWidth  = LcStateWidth + LcCountWidth;

   localparam int OtpProgTimeoutDefault = 4096;

   // Pairwise Hamming distance between all encodings is at least 5.
   localparam int OtpProgStateWidth = 9;
   typedef enum logic [OtpProgStateWidth-1:0] {
      IdleSt  = 9'b000011111,
      CheckSt = 9'b111110000,
      ReqSt   = 9'b110001100,
      ErrorSt = 9'b001101010
   } otp_prog_state_e;

   function automatic int vbits(input int x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

endpackage

// File: rtl/lc_ctrl_otp_prog_cnt.sv
// Redundant timeout counter: an up counter and its complement counting down.
// Any disagreement between the two copies raises err_o.
module lc_ctrl_otp_prog_cnt #(
   parameter int Width = 12
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             incr_en_i,
   output logic [Width-1:0] cnt_o,
   output logic             err_o
);

   logic [Width-1:0] r_cnt;
   logic [Width-1:0] r_cnt_n;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt   <= '0;
         r_cnt_n <= '1;
      end else if (clr_i) begin
         r_cnt   <= '0;
         r_cnt_n <= '1;
      end else if (incr_en_i) begin
         r_cnt   <= r_cnt + Width'(1);
         r_cnt_n <= r_cnt_n - Width'(1);
      end
   end

   assign cnt_o = r_cnt;
   assign err_o = ((r_cnt ^ r_cnt_n) != {Width{1'b1}});

endmodule

// File: rtl/lc_ctrl_otp_prog.sv
// Issues one LC partition programming request to OTP per transition command,
// with a local never-clear-a-programmed-bit precheck and timeout supervision.
module lc_ctrl_otp_prog
   import lc_ctrl_otp_prog_pkg::*;
#(
   parameter int DataWidth     = LcDataWidth,
   parameter int TimeoutCycles = OtpProgTimeoutDefault,
   localparam int CntWidth     = vbits(TimeoutCycles)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 prog_start_i,
   input  logic [DataWidth-1:0] cur_data_i,
   input  logic [DataWidth-1:0] next_data_i,
   input  lc_tx_t               escalate_en_i,
   output logic                 prog_busy_o,
   output logic                 prog_done_o,
   output logic                 precheck_err_o,
   output logic                 prog_err_o,
   output logic                 timeout_err_o,
   output logic                 fsm_err_o,
   output logic                 lc_req_o,
   output logic [DataWidth-1:0] lc_data_o,
   input  logic                 lc_ack_i,
   input  logic                 lc_err_i
);

   otp_prog_state_e      r_state;
   logic [DataWidth-1:0] r_data;
   logic                 r_done;
   logic                 r_pre_err;
   logic                 r_prog_err;
   logic                 r_tmo_err;
   logic                 r_fsm_err;
   logic                 r_req;

   logic [CntWidth-1:0]  w_cnt;
   logic                 w_cnt_err;
   logic                 w_cnt_clr;
   logic                 w_cnt_incr;
   logic                 w_viol;
   logic                 w_esc;
   logic                 w_timeout;

   assign w_viol     = |(cur_data_i & ~r_data);
   assign w_esc      = (escalate_en_i != Off);
   assign w_cnt_clr  = (r_state == CheckSt);
   assign w_cnt_incr = (r_state == ReqSt);
   assign w_timeout  = (w_cnt == CntWidth'(TimeoutCycles - 1));

   lc_ctrl_otp_prog_cnt #(
      .Width (CntWidth)
   ) u_cnt (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clr_i     (w_cnt_clr),
      .incr_en_i (w_cnt_incr),
      .cnt_o     (w_cnt),
      .err_o     (w_cnt_err)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= IdleSt;
         r_data     <= '0;
         r_done     <= 1'b0;
         r_pre_err  <= 1'b0;
         r_prog_err <= 1'b0;
         r_tmo_err  <= 1'b0;
         r_fsm_err  <= 1'b0;
         r_req      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IdleSt: begin
               r_req <= 1'b0;
               if (prog_start_i) begin
                  r_data    <= next_data_i;
                  r_pre_err <= 1'b0;
                  r_state   <= CheckSt;
               end
            end
            CheckSt: begin
               if (w_viol) begin
                  r_pre_err <= 1'b1;
                  r_done    <= 1'b1;
                  r_state   <= IdleSt;
               end else begin
                  r_req   <= 1'b1;
                  r_state <= ReqSt;
               end
            end
            ReqSt: begin
               // An ack in the final allowed cycle still counts as success.
               if (lc_ack_i) begin
                  r_req  <= 1'b0;
                  r_done <= 1'b1;
                  if (lc_err_i) begin
                     r_prog_err <= 1'b1;
                     r_state    <= ErrorSt;
                  end else begin
                     r_state <= IdleSt;
                  end
               end else if (w_timeout) begin
                  r_req     <= 1'b0;
                  r_done    <= 1'b1;
                  r_tmo_err <= 1'b1;
                  r_state   <= ErrorSt;
               end
            end
            ErrorSt: begin
               r_req <= 1'b0;
            end
            default: begin
               r_req     <= 1'b0;
               r_fsm_err <= 1'b1;
               r_state   <= ErrorSt;
            end
         endcase

         // Lockdown overrides whatever the case decided, except done.
         if (w_esc || w_cnt_err) begin
            r_req     <= 1'b0;
            r_fsm_err <= 1'b1;
            r_state   <= ErrorSt;
         end
      end
   end

   assign prog_busy_o    = (r_state != IdleSt);
   assign prog_done_o    = r_done;
   assign precheck_err_o = r_pre_err;
   assign prog_err_o     = r_prog_err;
   assign timeout_err_o  = r_tmo_err;
   assign fsm_err_o      = r_fsm_err;
   assign lc_req_o       = r_req;
   assign lc_data_o      = r_data;

endmodule
